csr_commit_unit: RTL and testbench

Commit-side initiator for the CSR file. It accepts up to `COMMIT_CSR_CHANNEL_NUM` retiring CSR instructions per cycle from commit and buffers them in an in-order FIFO. It drains them onto the csrfile read/write channels as atomic read-modify-write operations and returns each old CSR value to writeback one cycle later. It sits between the commit stage and `csrfile`, and owns the `commit_csrf_*` port set.

---
 rtl/csr_commit_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_csr_commit_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_commit_unit.sv
// -----------------------------------------------------------------------------
// csr_commit_unit
//
// Commit-side initiator for the CSR file. Retiring CSR instructions, up to CH
// per cycle, are pushed into an in-order FIFO. Each cycle a drain group of up
// to CH head entries is issued to csrfile as atomic read-modify-write
// operations. The old CSR value of each drained entry is returned to
// writeback one cycle later.
//
// Optional feature macro: CSR_COMMIT_FORWARD_EN
//   defined   : same-address entries drain together; later entries take their
//               old value from the nearest earlier writer in the group, and
//               only the last writer to an address asserts its write enable.
//   undefined : the drain group stops before the first entry whose address
//               repeats an earlier entry of the group; that entry drains next
//               cycle and reads the committed value.
//
// Ports
//   clk                     clock, rising edge
//   rst                     synchronous active-low reset
//   commit_csrcu_valid      push mask (contiguous from lane 0)
//   commit_csrcu_op/addr/src/tag   per-lane instruction fields
//   csrcu_commit_ready      high when at least CH entries are free
//   commit_csrf_read_addr   csrfile read address per channel
//   csrf_commit_read_data   csrfile read data (combinational)
//   commit_csrf_write_addr/_data/_we   csrfile write channel
//   csrcu_wb_valid/_data/_tag/_illegal registered writeback results
// -----------------------------------------------------------------------------
module csr_commit_unit #(
    parameter int CH             = 4,
    parameter int DEPTH          = 8,
    parameter int CSR_ADDR_WIDTH = 12,
    parameter int REG_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CH-1:0]             commit_csrcu_valid,
    input  logic [1:0]                commit_csrcu_op   [CH],
    input  logic [CSR_ADDR_WIDTH-1:0] commit_csrcu_addr [CH],
    input  logic [REG_DATA_WIDTH-1:0] commit_csrcu_src  [CH],
    input  logic [5:0]                commit_csrcu_tag  [CH],
    output logic                      csrcu_commit_ready,
    output logic [CSR_ADDR_WIDTH-1:0] commit_csrf_read_addr  [CH],
    input  logic [REG_DATA_WIDTH-1:0] csrf_commit_read_data  [CH],
    output logic [CSR_ADDR_WIDTH-1:0] commit_csrf_write_addr [CH],
    output logic [REG_DATA_WIDTH-1:0] commit_csrf_write_data [CH],
    output logic [CH-1:0]             commit_csrf_we,
    output logic [CH-1:0]             csrcu_wb_valid,
    output logic [REG_DATA_WIDTH-1:0] csrcu_wb_data [CH],
    output logic [5:0]                csrcu_wb_tag  [CH],
    output logic [CH-1:0]             csrcu_wb_illegal
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    localparam logic [1:0] OP_RW = 2'b00;
    localparam logic [1:0] OP_RS = 2'b01;
    localparam logic [1:0] OP_RC = 2'b10;
    localparam logic [1:0] OP_RD = 2'b11;

    // CSRs with address bits [11:10] == 2'b11 are read-only
    function automatic logic is_ro(input logic [CSR_ADDR_WIDTH-1:0] a);
        return a[CSR_ADDR_WIDTH-1 -: 2] == 2'b11;
    endfunction

    // New CSR value for one read-modify-write; read-only op keeps the old value
    function automatic logic [REG_DATA_WIDTH-1:0] apply_op(
        input logic [1:0]                op,
        input logic [REG_DATA_WIDTH-1:0] old,
        input logic [REG_DATA_WIDTH-1:0] src
    );
        logic [REG_DATA_WIDTH-1:0] res;
        case (op)
            OP_RW:   res = src;
            OP_RS:   res = old | src;
            OP_RC:   res = old & ~src;
            default: res = old;
        endcase
        return res;
    endfunction

    // FIFO storage and pointers (extra MSB separates full from empty)
    logic [1:0]                fifo_op_r   [DEPTH];
    logic [CSR_ADDR_WIDTH-1:0] fifo_addr_r [DEPTH];
    logic [REG_DATA_WIDTH-1:0] fifo_src_r  [DEPTH];
    logic [5:0]                fifo_tag_r  [DEPTH];
    logic [PW-1:0]             wptr_r;
    logic [PW-1:0]             rptr_r;
    logic                      ready_r;

    logic [PW-1:0]             count_s;
    logic [PW-1:0]             push_n_s;
    logic [PW-1:0]             drain_n_s;
    logic [PW-1:0]             next_count_s;
    logic                      push_stop_s;
    logic                      drain_stop_s;

    logic [IW-1:0]             h_idx_s  [CH];
    logic [1:0]                h_op_s   [CH];
    logic [CSR_ADDR_WIDTH-1:0] h_addr_s [CH];
    logic [REG_DATA_WIDTH-1:0] h_src_s  [CH];
    logic [5:0]                h_tag_s  [CH];
    logic [CH-1:0]             drain_s;
    logic [CH-1:0]             we_raw_s;
    logic [CH-1:0]             we_s;
    logic [CH-1:0]             ill_s;
    logic [REG_DATA_WIDTH-1:0] old_s [CH];
    logic [REG_DATA_WIDTH-1:0] new_s [CH];

    // Writeback registers
    logic [CH-1:0]             wb_valid_r;
    logic [CH-1:0]             wb_illegal_r;
    logic [REG_DATA_WIDTH-1:0] wb_data_r [CH];
    logic [5:0]                wb_tag_r  [CH];

    assign count_s = wptr_r - rptr_r;

    // Push length: contiguous valid lanes from lane 0, dropped when not ready
    always_comb begin
        push_stop_s = 1'b0;
        push_n_s    = {PW{1'b0}};
        for (int k = 0; k < CH; k++) begin
            push_stop_s = push_stop_s | ~commit_csrcu_valid[k];
            push_n_s    = push_stop_s ? push_n_s : PW'(k + 1);
        end
        push_n_s     = ready_r ? push_n_s : {PW{1'b0}};
        next_count_s = (wptr_r + push_n_s) - (rptr_r + drain_n_s);
    end

    // Drain group selection: head entries in order, cut at empty slots and,
    // without forwarding, at the first repeated address
    always_comb begin
        drain_stop_s = 1'b0;
        drain_n_s    = {PW{1'b0}};
        drain_s      = {CH{1'b0}};
        for (int k = 0; k < CH; k++) begin
            h_idx_s[k]   = rptr_r[IW-1:0] + IW'(k);
            h_op_s[k]    = fifo_op_r[h_idx_s[k]];
            h_addr_s[k]  = fifo_addr_r[h_idx_s[k]];
            h_src_s[k]   = fifo_src_r[h_idx_s[k]];
            h_tag_s[k]   = fifo_tag_r[h_idx_s[k]];
            drain_stop_s = drain_stop_s | (PW'(k) >= count_s);
`ifndef CSR_COMMIT_FORWARD_EN
            for (int j = 0; j < k; j++) begin
                drain_stop_s = drain_stop_s | (drain_s[j] & (h_addr_s[j] == h_addr_s[k]));
            end
`endif
            drain_s[k] = ~drain_stop_s;
            drain_n_s  = drain_s[k] ? PW'(k + 1) : drain_n_s;
        end
    end

    // Read-modify-write values, write enables and illegal-write flags
    always_comb begin
        we_raw_s = {CH{1'b0}};
        ill_s    = {CH{1'b0}};
        for (int k = 0; k < CH; k++) begin
            old_s[k] = csrf_commit_read_data[k];
`ifdef CSR_COMMIT_FORWARD_EN
            // ascending scan leaves the nearest earlier writer's value
            for (int j = 0; j < k; j++) begin
                old_s[k] = (we_raw_s[j] && (h_addr_s[j] == h_addr_s[k])) ? new_s[j] : old_s[k];
            end
`endif
            new_s[k]    = apply_op(h_op_s[k], old_s[k], h_src_s[k]);
            we_raw_s[k] = drain_s[k] & (h_op_s[k] != OP_RD) & ~is_ro(h_addr_s[k]);
            ill_s[k]    = drain_s[k] & (h_op_s[k] != OP_RD) & is_ro(h_addr_s[k]);
        end
        we_s = we_raw_s;
`ifdef CSR_COMMIT_FORWARD_EN
        // a later writer to the same address supersedes an earlier one
        for (int k = 0; k < CH; k++) begin
            for (int j = k + 1; j < CH; j++) begin
                we_s[k] = we_s[k] & ~(we_raw_s[j] & (h_addr_s[j] == h_addr_s[k]));
            end
        end
`endif
    end

    // csrfile channel drive; idle channels park at all-ones addresses
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            commit_csrf_read_addr[k]  = drain_s[k] ? h_addr_s[k] : {CSR_ADDR_WIDTH{1'b1}};
            commit_csrf_write_addr[k] = drain_s[k] ? h_addr_s[k] : {CSR_ADDR_WIDTH{1'b1}};
            commit_csrf_write_data[k] = drain_s[k] ? new_s[k] : {REG_DATA_WIDTH{1'b0}};
        end
        commit_csrf_we = we_s & {CH{rst}};
    end

    // FIFO storage: accepted lanes written at the tail
    always_ff @(posedge clk) begin
        for (int k = 0; k < CH; k++) begin
            if (rst && (PW'(k) < push_n_s)) begin
                fifo_op_r[wptr_r[IW-1:0] + IW'(k)]   <= commit_csrcu_op[k];
                fifo_addr_r[wptr_r[IW-1:0] + IW'(k)] <= commit_csrcu_addr[k];
                fifo_src_r[wptr_r[IW-1:0] + IW'(k)]  <= commit_csrcu_src[k];
                fifo_tag_r[wptr_r[IW-1:0] + IW'(k)]  <= commit_csrcu_tag[k];
            end
        end
    end

    // Pointers, readiness and writeback registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_r       <= {PW{1'b0}};
            rptr_r       <= {PW{1'b0}};
            ready_r      <= 1'b1;
            wb_valid_r   <= {CH{1'b0}};
            wb_illegal_r <= {CH{1'b0}};
            for (int k = 0; k < CH; k++) begin
                wb_data_r[k] <= {REG_DATA_WIDTH{1'b0}};
                wb_tag_r[k]  <= 6'd0;
            end
        end else begin
            wptr_r       <= wptr_r + push_n_s;
            rptr_r       <= rptr_r + drain_n_s;
            ready_r      <= (next_count_s <= PW'(DEPTH - CH));
            wb_valid_r   <= drain_s;
            wb_illegal_r <= ill_s;
            for (int k = 0; k < CH; k++) begin
                wb_data_r[k] <= drain_s[k] ? old_s[k] : {REG_DATA_WIDTH{1'b0}};
                wb_tag_r[k]  <= drain_s[k] ? h_tag_s[k] : 6'd0;
            end
        end
    end

    assign csrcu_commit_ready = ready_r;
    assign csrcu_wb_valid     = wb_valid_r;
    assign csrcu_wb_illegal   = wb_illegal_r;
    assign csrcu_wb_data      = wb_data_r;
    assign csrcu_wb_tag       = wb_tag_r;

endmodule

// File: tb/tb_csr_commit_unit.sv
// Directed testbench for csr_commit_unit with a behavioural csrfile.
module tb_csr_commit_unit;

    localparam int CH = 4;
    localparam int AW = 12;
    localparam int DW = 32;
`ifdef CSR_COMMIT_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic [CH-1:0] valid;
    logic [1:0]    op   [CH];
    logic [AW-1:0] addr [CH];
    logic [DW-1:0] src  [CH];
    logic [5:0]    tag  [CH];
    logic          ready;
    logic [AW-1:0] raddr [CH];
    logic [DW-1:0] rdata [CH];
    logic [AW-1:0] waddr [CH];
    logic [DW-1:0] wdata [CH];
    logic [CH-1:0] we;
    logic [CH-1:0] wb_valid;
    logic [DW-1:0] wb_data [CH];
    logic [5:0]    wb_tag  [CH];
    logic [CH-1:0] wb_illegal;

    csr_commit_unit dut (
        .clk                    (clk),
        .rst                    (rst),
        .commit_csrcu_valid     (valid),
        .commit_csrcu_op        (op),
        .commit_csrcu_addr      (addr),
        .commit_csrcu_src       (src),
        .commit_csrcu_tag       (tag),
        .csrcu_commit_ready     (ready),
        .commit_csrf_read_addr  (raddr),
        .csrf_commit_read_data  (rdata),
        .commit_csrf_write_addr (waddr),
        .commit_csrf_write_data (wdata),
        .commit_csrf_we         (we),
        .csrcu_wb_valid         (wb_valid),
        .csrcu_wb_data          (wb_data),
        .csrcu_wb_tag           (wb_tag),
        .csrcu_wb_illegal       (wb_illegal)
    );

    // csrfile model
    bit [DW-1:0] csr_mem [4096];
    bit          preset_en = 1'b0;
    bit [AW-1:0] preset_addr;
    bit [DW-1:0] preset_data;

    always_comb begin
        for (int k = 0; k < CH; k++) rdata[k] = csr_mem[raddr[k]];
    end

    always @(posedge clk) begin
        if (preset_en) csr_mem[preset_addr] <= preset_data;
        for (int k = 0; k < CH; k++) begin
            if (we[k] === 1'b1) csr_mem[waddr[k]] <= wdata[k];
        end
    end

    // writeback monitor
    logic [DW-1:0] got_data [$];
    logic [5:0]    got_tag  [$];
    logic          got_ill  [$];
    int            wb_cycles = 0;

    always @(negedge clk) begin
        if (!$isunknown(wb_valid) && wb_valid != 4'b0000) wb_cycles++;
        for (int k = 0; k < CH; k++) begin
            if (wb_valid[k] === 1'b1) begin
                got_data.push_back(wb_data[k]);
                got_tag.push_back(wb_tag[k]);
                got_ill.push_back(wb_illegal[k]);
            end
        end
    end

    // reference model for the mixed sequence
    bit [DW-1:0]   refm [4096];
    logic [DW-1:0] exp_data [$];
    logic [5:0]    exp_tag  [$];
    logic          exp_ill  [$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic preset(input logic [AW-1:0] a, input logic [DW-1:0] d);
        preset_en   = 1'b1;
        preset_addr = a;
        preset_data = d;
        tick();
        preset_en   = 1'b0;
    endtask

    task automatic set_lane(input int k, input logic [1:0] o, input logic [AW-1:0] a,
                            input logic [DW-1:0] s, input logic [5:0] t);
        op[k] = o; addr[k] = a; src[k] = s; tag[k] = t;
    endtask

    task automatic model_lane(input int k);
        logic [DW-1:0] old;
        logic [DW-1:0] nw;
        logic          ro;
        old = refm[addr[k]];
        ro  = (addr[k][11:10] == 2'b11);
        case (op[k])
            2'b00:   nw = src[k];
            2'b01:   nw = old | src[k];
            2'b10:   nw = old & ~src[k];
            default: nw = old;
        endcase
        exp_data.push_back(old);
        exp_tag.push_back(tag[k]);
        exp_ill.push_back(ro && (op[k] != 2'b11));
        if (op[k] != 2'b11 && !ro) refm[addr[k]] = nw;
    endtask

    // push all four lanes once ready is seen, updating the reference model
    task automatic push4_model();
        int w;
        w = 0;
        while (ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        if (w == 50) check("ready_timeout", {31'd0, ready}, 32'd1);
        for (int k = 0; k < CH; k++) model_lane(k);
        valid = 4'b1111;
        tick();
        valid = 4'b0000;
    endtask

    initial begin
        int base;
        int c0;
        int n;
        logic [AW-1:0] addrs [4];

        valid = 4'b0000;
        for (int k = 0; k < CH; k++) set_lane(k, 2'b00, 12'h000, 32'd0, 6'd0);

        // reset held for 3 cycles with random pushes
        for (int c = 0; c < 3; c++) begin
            valid = 4'b1111;
            for (int k = 0; k < CH; k++)
                set_lane(k, 2'($urandom), 12'($urandom), $urandom, 6'($urandom));
            tick();
            check("rst_we", {28'd0, we}, 32'd0);
            check("rst_wb_valid", {28'd0, wb_valid}, 32'd0);
            check("rst_ready", {31'd0, ready}, 32'd1);
        end
        valid = 4'b0000;
        rst   = 1'b1;
        tick();
        check("post_rst_we", {28'd0, we}, 32'd0);
        check("post_rst_raddr_idle", {20'd0, raddr[0]}, 32'h0000_0FFF);
        check("post_rst_ready", {31'd0, ready}, 32'd1);
        check("post_rst_wb_valid", {28'd0, wb_valid}, 32'd0);

        // single RW to mscratch
        preset(12'h340, 32'h0000_0011);
        set_lane(0, 2'b00, 12'h340, 32'h0000_005A, 6'd5);
        valid = 4'b0001;
        tick();
        valid = 4'b0000;
        check("rw_we", {28'd0, we}, 32'd1);
        check("rw_wdata", wdata[0], 32'h0000_005A);
        check("rw_waddr", {20'd0, waddr[0]}, 32'h0000_0340);
        check("rw_raddr", {20'd0, raddr[0]}, 32'h0000_0340);
        tick();
        check("rw_wb_valid", {28'd0, wb_valid}, 32'd1);
        check("rw_wb_data", wb_data[0], 32'h0000_0011);
        check("rw_wb_tag", {26'd0, wb_tag[0]}, 32'd5);
        check("rw_mem", csr_mem[12'h340], 32'h0000_005A);
        tick();
        check("rw_wb_valid_drop", {28'd0, wb_valid}, 32'd0);

        // RS/RC/RS/read on mstatus in one push
        preset(12'h300, 32'h0000_0000);
        idle(2);
        base = got_data.size();
        c0   = wb_cycles;
        set_lane(0, 2'b01, 12'h300, 32'h0000_0008, 6'd1);
        set_lane(1, 2'b10, 12'h300, 32'h0000_0008, 6'd2);
        set_lane(2, 2'b01, 12'h300, 32'h0000_0080, 6'd3);
        set_lane(3, 2'b11, 12'h300, 32'h0000_0000, 6'd4);
        valid = 4'b1111;
        tick();
        valid = 4'b0000;
        check("ms_first_we", {28'd0, we}, FWD ? 32'h4 : 32'h1);
        n = 0;
        while (got_data.size() < base + 4 && n < 20) begin
            tick();
            n++;
        end
        check("ms_count", got_data.size() - base, 32'd4);
        if (got_data.size() >= base + 4) begin
            check("ms_res0", got_data[base],     32'h0000_0000);
            check("ms_res1", got_data[base + 1], 32'h0000_0008);
            check("ms_res2", got_data[base + 2], 32'h0000_0000);
            check("ms_res3", got_data[base + 3], 32'h0000_0080);
            check("ms_tag3", {26'd0, got_tag[base + 3]}, 32'd4);
        end
        tick();
        check("ms_mem", csr_mem[12'h300], 32'h0000_0080);
        check("ms_groups", wb_cycles - c0, FWD ? 32'd1 : 32'd4);

        // RW to read-only mhartid
        preset(12'hF14, 32'h0000_0007);
        set_lane(0, 2'b00, 12'hF14, 32'h0000_0055, 6'd9);
        valid = 4'b0001;
        tick();
        valid = 4'b0000;
        check("ro_we", {28'd0, we}, 32'd0);
        check("ro_raddr", {20'd0, raddr[0]}, 32'h0000_0F14);
        tick();
        check("ro_illegal", {28'd0, wb_illegal}, 32'd1);
        check("ro_wb_data", wb_data[0], 32'h0000_0007);
        check("ro_mem", csr_mem[12'hF14], 32'h0000_0007);

        // full condition and 20 mixed ops crossing pointer wrap
        idle(6);
        addrs[0] = 12'h340; addrs[1] = 12'h300; addrs[2] = 12'h341; addrs[3] = 12'hF14;
        for (int a = 0; a < 4; a++) refm[addrs[a]] = csr_mem[addrs[a]];
        base = got_data.size();
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < CH; k++) begin
                int i;
                i = g * 4 + k;
                set_lane(k, 2'(i), (g < 2) ? 12'h340 : addrs[(i * 3 + g) % 4],
                         (32'h0101_0101 * (i + 1)) ^ (32'd1 << i), 6'(i + 10));
            end
            push4_model();
            if (g == 1) check("full_ready", {31'd0, ready}, FWD ? 32'd1 : 32'd0);
        end
        n = 0;
        while (got_data.size() < base + 20 && n < 200) begin
            tick();
            n++;
        end
        check("wrap_count", got_data.size() - base, 32'd20);
        for (int i = 0; i < 20; i++) begin
            if (base + i < got_data.size()) begin
                check($sformatf("wrap_data%0d", i), got_data[base + i], exp_data[i]);
                check($sformatf("wrap_tag%0d", i), {26'd0, got_tag[base + i]}, {26'd0, exp_tag[i]});
                check($sformatf("wrap_ill%0d", i), {31'd0, got_ill[base + i]}, {31'd0, exp_ill[i]});
            end
        end
        tick();
        for (int a = 0; a < 4; a++)
            check($sformatf("wrap_mem%0d", a), csr_mem[addrs[a]], refm[addrs[a]]);

        // reset with entries still queued
        preset(12'h342, 32'h0000_0033);
        idle(2);
        for (int k = 0; k < CH; k++) set_lane(k, 2'b11, 12'h342, 32'h0000_FFFF, 6'(k + 40));
        valid = 4'b1111;
        tick();
        set_lane(0, 2'b00, 12'h342, 32'h0000_DEAD, 6'd50);
        set_lane(1, 2'b00, 12'h342, 32'h0000_BEEF, 6'd51);
        valid = 4'b0011;
        tick();
        valid = 4'b0000;
        rst   = 1'b0;
        #1;
        check("mid_rst_we_cycle", {28'd0, we}, 32'd0);
        for (int c = 0; c < 2; c++) begin
            tick();
            check("mid_rst_we", {28'd0, we}, 32'd0);
            check("mid_rst_wb_valid", {28'd0, wb_valid}, 32'd0);
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("after_rst_we", {28'd0, we}, 32'd0);
            check("after_rst_wb_valid", {28'd0, wb_valid}, 32'd0);
        end
        check("after_rst_mem", csr_mem[12'h342], 32'h0000_0033);
        check("after_rst_ready", {31'd0, ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
